// File: rtl/id_pkg.sv
// Shared types and constants for the IF/ID instruction queue.
package id_pkg;

    typedef enum logic {
        NORMAL  = 1'b0,
        WAIT_DS = 1'b1
    } state_e;

    localparam int unsigned ID_INSTR_W = 32;
    localparam int unsigned ID_PC_W    = 32;
    localparam int unsigned PC_STEP    = 4;

    typedef struct packed {
        logic [ID_INSTR_W-1:0] instr;
        logic [ID_PC_W-1:0]    pc;
    } entry_t;

endpackage

// File: rtl/id_instr_queue_if.sv
// Fetch-side and decode-side signals of the IF/ID instruction queue.
interface id_instr_queue_if #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned INSTR_W = 32,
    parameter int unsigned PC_W    = 32
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] in_instr;
    logic [PC_W-1:0]    in_pc;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [PC_W-1:0]    out_pc;
    logic [PC_W-1:0]    out_pc_plus_4;
    logic               out_is_ds;
    logic               dec_is_branch;
    logic               redirect;
    logic               flush;
    logic               ds_pending;
    logic [CNT_W-1:0]   count;

    modport master (
        output in_valid, in_instr, in_pc, out_ready, dec_is_branch, redirect, flush,
        input  in_ready, out_valid, out_instr, out_pc, out_pc_plus_4, out_is_ds,
               ds_pending, count
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready, dec_is_branch, redirect, flush,
        output in_ready, out_valid, out_instr, out_pc, out_pc_plus_4, out_is_ds,
               ds_pending, count
    );

endinterface

// File: rtl/id_queue_ram.sv
// Queue storage: register array, one synchronous write port, combinational read.
module id_queue_ram #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/id_instr_queue.sv
// IF/ID instruction FIFO that keeps the branch delay slot across a taken redirect
// and waits for it when it has not been fetched yet.
module id_instr_queue
    import id_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned INSTR_W = 32,
    parameter int unsigned PC_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    id_instr_queue_if.slave   bus
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned ENT_W = INSTR_W + PC_W;

    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [PTR_W-1:0] wr_q, wr_d;
    state_e           state_q, state_d;
    logic             last_br_q, last_br_d;

    logic             in_ready;
    logic             out_valid;
    logic             push;
    logic             pop;
    logic             taken;
    logic             ram_we;
    logic [ENT_W-1:0] ram_rdata;
    logic [PC_W-1:0]  head_pc;

    assign in_ready  = count_q < CNT_W'(DEPTH);
    assign out_valid = count_q != '0;
    assign push      = bus.in_valid & in_ready;
    assign pop       = out_valid & bus.out_ready;
    assign taken     = pop & bus.dec_is_branch & bus.redirect;

    id_queue_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W),
        .AW    (PTR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_q),
        .wdata ({bus.in_instr, bus.in_pc}),
        .raddr (rd_q),
        .rdata (ram_rdata)
    );

    // Next-state: flush beats everything; a taken redirect collapses the queue to the delay slot.
    always_comb begin
        count_d   = count_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        state_d   = state_q;
        last_br_d = last_br_q;
        ram_we    = 1'b0;

        if (bus.flush) begin
            count_d   = '0;
            rd_d      = '0;
            wr_d      = '0;
            state_d   = NORMAL;
            last_br_d = 1'b0;
        end else if (state_q == WAIT_DS) begin
            // Queue is empty here, so rd_q == wr_q and the pushed word becomes the head.
            if (push) begin
                ram_we  = 1'b1;
                wr_d    = wr_q + PTR_W'(1);
                count_d = CNT_W'(1);
                state_d = NORMAL;
            end
        end else begin
            if (pop) begin
                last_br_d = bus.dec_is_branch;
            end
            if (taken) begin
                if (count_q >= CNT_W'(2)) begin
                    rd_d    = rd_q + PTR_W'(1);
                    wr_d    = rd_q + PTR_W'(2);
                    count_d = CNT_W'(1);
                end else if (push) begin
                    ram_we  = 1'b1;
                    rd_d    = wr_q;
                    wr_d    = wr_q + PTR_W'(1);
                    count_d = CNT_W'(1);
                end else begin
                    rd_d    = wr_q;
                    count_d = '0;
                    state_d = WAIT_DS;
                end
            end else begin
                if (push) begin
                    ram_we = 1'b1;
                    wr_d   = wr_q + PTR_W'(1);
                end
                if (pop) begin
                    rd_d = rd_q + PTR_W'(1);
                end
                count_d = count_q + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q   <= '0;
            rd_q      <= '0;
            wr_q      <= '0;
            state_q   <= NORMAL;
            last_br_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            state_q   <= state_d;
            last_br_q <= last_br_d;
        end
    end

    assign head_pc           = ram_rdata[PC_W-1:0];
    assign bus.in_ready      = in_ready;
    assign bus.out_valid     = out_valid;
    assign bus.out_instr     = ram_rdata[ENT_W-1 -: INSTR_W];
    assign bus.out_pc        = head_pc;
    assign bus.out_pc_plus_4 = head_pc + PC_W'(PC_STEP);
    assign bus.out_is_ds     = last_br_q & out_valid;
    assign bus.ds_pending    = state_q == WAIT_DS;
    assign bus.count         = count_q;

    // A redirect is only meaningful alongside the pop of a branch.
    redirect_needs_branch_pop: assert property (
        @(posedge clk) disable iff (!rst)
        (bus.redirect && !bus.flush) |-> (pop && bus.dec_is_branch)
    ) else $error("redirect asserted without a branch pop");

endmodule

// File: tb/tb_id_instr_queue.sv
// Bench for id_instr_queue: directed vector table, corner sequences and random traffic vs a queue model.
module tb_id_instr_queue;
    import id_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic clk;
    logic rst;

    id_instr_queue_if #(.DEPTH(DEPTH), .INSTR_W(32), .PC_W(32)) bus ();

    id_instr_queue #(.DEPTH(DEPTH), .INSTR_W(32), .PC_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    entry_t mq[$];
    bit     m_lb;
    bit     m_wait;

    typedef struct {
        logic        iv;
        logic [31:0] pc;
        logic        ordy;
        logic        br;
        logic        rd;
        logic        fl;
        int          cnt;
        logic [31:0] head;
        logic        ds;
        logic        dsp;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        logic [31:0] w;
        w = {16'hC0DE, pc[15:0]};
        return w;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic add(input logic iv, input logic [31:0] pc, input logic ordy, input logic br,
                       input logic rd, input logic fl, input int cnt, input logic [31:0] head,
                       input logic ds, input logic dsp);
        vec_t v;
        v.iv = iv; v.pc = pc; v.ordy = ordy; v.br = br; v.rd = rd; v.fl = fl;
        v.cnt = cnt; v.head = head; v.ds = ds; v.dsp = dsp;
        tbl.push_back(v);
    endtask

    // Reference: queue of entries, delay-slot flag and waiting-for-slot flag.
    task automatic model_edge(input logic iv, input logic [31:0] instr, input logic [31:0] pc,
                              input logic ordy, input logic br, input logic rd, input logic fl);
        int     sz;
        bit     push_m;
        bit     pop_m;
        entry_t e;
        entry_t ds;
        sz     = mq.size();
        push_m = iv && (sz < int'(DEPTH));
        pop_m  = ordy && (sz != 0);
        e.instr = instr;
        e.pc    = pc;
        if (fl) begin
            mq.delete();
            m_lb   = 1'b0;
            m_wait = 1'b0;
        end else if (m_wait) begin
            if (push_m) begin
                mq.push_back(e);
                m_wait = 1'b0;
            end
        end else begin
            if (pop_m) m_lb = br;
            if (pop_m && br && rd) begin
                if (sz >= 2) begin
                    ds = mq[1];
                    mq.delete();
                    mq.push_back(ds);
                end else if (push_m) begin
                    mq.delete();
                    mq.push_back(e);
                end else begin
                    mq.delete();
                    m_wait = 1'b1;
                end
            end else begin
                if (pop_m) void'(mq.pop_front());
                if (push_m) mq.push_back(e);
            end
        end
    endtask

    task automatic cycle(input logic iv, input logic [31:0] instr, input logic [31:0] pc,
                         input logic ordy, input logic br, input logic rd, input logic fl);
        @(negedge clk);
        bus.in_valid      = iv;
        bus.in_instr      = instr;
        bus.in_pc         = pc;
        bus.out_ready     = ordy;
        bus.dec_is_branch = br;
        bus.redirect      = rd;
        bus.flush         = fl;
        @(posedge clk);
        model_edge(iv, instr, pc, ordy, br, rd, fl);
        #1;
    endtask

    task automatic check_model(input string tag);
        int sz;
        sz = mq.size();
        check({tag, ".count"},      64'(bus.count),      64'(sz));
        check({tag, ".out_valid"},  64'(bus.out_valid),  64'(sz != 0));
        check({tag, ".in_ready"},   64'(bus.in_ready),   64'(sz < int'(DEPTH)));
        check({tag, ".ds_pending"}, 64'(bus.ds_pending), 64'(m_wait));
        check({tag, ".out_is_ds"},  64'(bus.out_is_ds),  64'(m_lb && sz != 0));
        if (sz != 0) begin
            check({tag, ".out_pc"},    64'(bus.out_pc),        64'(mq[0].pc));
            check({tag, ".out_instr"}, 64'(bus.out_instr),     64'(mq[0].instr));
            check({tag, ".pc_plus_4"}, 64'(bus.out_pc_plus_4), 64'(mq[0].pc + 32'd4));
        end
    endtask

    initial begin
        rst               = 1'b0;
        bus.in_valid      = 1'b0;
        bus.in_instr      = '0;
        bus.in_pc         = '0;
        bus.out_ready     = 1'b0;
        bus.dec_is_branch = 1'b0;
        bus.redirect      = 1'b0;
        bus.flush         = 1'b0;
        m_lb   = 1'b0;
        m_wait = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("reset.count",      64'(bus.count),      64'd0);
        check("reset.out_valid",  64'(bus.out_valid),  64'd0);
        check("reset.in_ready",   64'(bus.in_ready),   64'd1);
        check("reset.out_is_ds",  64'(bus.out_is_ds),  64'd0);
        check("reset.ds_pending", 64'(bus.ds_pending), 64'd0);

        // Asynchronous reset mid-operation
        for (int i = 0; i < 3; i++) cycle(1'b1, instr_of(32'h80 + 32'(4 * i)), 32'h80 + 32'(4 * i), 1'b0, 1'b0, 1'b0, 1'b0);
        check("prerst.count", 64'(bus.count), 64'd3);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("midrst.count",      64'(bus.count),      64'd0);
        check("midrst.out_valid",  64'(bus.out_valid),  64'd0);
        check("midrst.in_ready",   64'(bus.in_ready),   64'd1);
        check("midrst.ds_pending", 64'(bus.ds_pending), 64'd0);
        mq.delete();
        m_lb   = 1'b0;
        m_wait = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // Fill / drain, full queue refuses push
        add(1, 32'h100, 0, 0, 0, 0, 1, 32'h100, 0, 0);
        add(1, 32'h104, 0, 0, 0, 0, 2, 32'h100, 0, 0);
        add(1, 32'h108, 0, 0, 0, 0, 3, 32'h100, 0, 0);
        add(1, 32'h10C, 0, 0, 0, 0, 4, 32'h100, 0, 0);
        add(1, 32'h110, 0, 0, 0, 0, 4, 32'h100, 0, 0);
        add(0, 32'h0,   1, 0, 0, 0, 3, 32'h104, 0, 0);
        add(0, 32'h0,   1, 0, 0, 0, 2, 32'h108, 0, 0);
        add(0, 32'h0,   1, 0, 0, 0, 1, 32'h10C, 0, 0);
        add(0, 32'h0,   1, 0, 0, 0, 0, 32'h0,   0, 0);
        // Delay-slot flag held through a stall
        add(1, 32'h200, 0, 0, 0, 0, 1, 32'h200, 0, 0);
        add(1, 32'h204, 0, 0, 0, 0, 2, 32'h200, 0, 0);
        add(0, 32'h0,   1, 1, 0, 0, 1, 32'h204, 1, 0);
        add(0, 32'h0,   0, 0, 0, 0, 1, 32'h204, 1, 0);
        add(0, 32'h0,   0, 0, 0, 0, 1, 32'h204, 1, 0);
        add(0, 32'h0,   0, 0, 0, 0, 1, 32'h204, 1, 0);
        add(0, 32'h0,   1, 0, 0, 0, 0, 32'h0,   0, 0);
        add(1, 32'h208, 0, 0, 0, 0, 1, 32'h208, 0, 0);
        add(0, 32'h0,   1, 0, 0, 0, 0, 32'h0,   0, 0);
        // Redirect with the slot already queued
        add(1, 32'h300, 0, 0, 0, 0, 1, 32'h300, 0, 0);
        add(1, 32'h304, 0, 0, 0, 0, 2, 32'h300, 0, 0);
        add(1, 32'h308, 0, 0, 0, 0, 3, 32'h300, 0, 0);
        add(1, 32'h30C, 0, 0, 0, 0, 4, 32'h300, 0, 0);
        add(0, 32'h0,   1, 1, 1, 0, 1, 32'h304, 1, 0);
        add(0, 32'h0,   1, 0, 0, 0, 0, 32'h0,   0, 0);
        // Redirect with empty queue behind the branch -> WAIT_DS
        add(1, 32'h400, 0, 0, 0, 0, 1, 32'h400, 0, 0);
        add(0, 32'h0,   1, 1, 1, 0, 0, 32'h0,   0, 1);
        add(0, 32'h0,   1, 0, 0, 0, 0, 32'h0,   0, 1);
        add(1, 32'h404, 0, 0, 0, 0, 1, 32'h404, 1, 0);
        add(0, 32'h0,   1, 0, 0, 0, 0, 32'h0,   0, 0);
        // Flush wins over push, pop and redirect
        add(1, 32'h4F0, 0, 0, 0, 0, 1, 32'h4F0, 0, 0);
        add(1, 32'h4F4, 0, 0, 0, 0, 2, 32'h4F0, 0, 0);
        add(1, 32'h500, 1, 1, 1, 1, 0, 32'h0,   0, 0);
        add(0, 32'h0,   0, 0, 0, 0, 0, 32'h0,   0, 0);
        // Single entry + same-cycle push keeps the pushed word as slot
        add(1, 32'h600, 0, 0, 0, 0, 1, 32'h600, 0, 0);
        add(1, 32'h604, 1, 1, 1, 0, 1, 32'h604, 1, 0);
        add(0, 32'h0,   1, 0, 0, 0, 0, 32'h0,   0, 0);
        // Flush while waiting for the slot
        add(1, 32'h700, 0, 0, 0, 0, 1, 32'h700, 0, 0);
        add(0, 32'h0,   1, 1, 1, 0, 0, 32'h0,   0, 1);
        add(0, 32'h0,   0, 0, 0, 1, 0, 32'h0,   0, 0);
        add(1, 32'h704, 0, 0, 0, 0, 1, 32'h704, 0, 0);
        add(0, 32'h0,   1, 0, 0, 0, 0, 32'h0,   0, 0);
        // Full queue with pop still refuses push; push+pop holds count
        add(1, 32'h800, 0, 0, 0, 0, 1, 32'h800, 0, 0);
        add(1, 32'h804, 0, 0, 0, 0, 2, 32'h800, 0, 0);
        add(1, 32'h808, 0, 0, 0, 0, 3, 32'h800, 0, 0);
        add(1, 32'h80C, 0, 0, 0, 0, 4, 32'h800, 0, 0);
        add(1, 32'h810, 1, 0, 0, 0, 3, 32'h804, 0, 0);
        add(1, 32'h814, 1, 0, 0, 0, 3, 32'h808, 0, 0);
        add(0, 32'h0,   1, 0, 0, 0, 2, 32'h80C, 0, 0);
        add(0, 32'h0,   1, 0, 0, 0, 1, 32'h814, 0, 0);
        add(0, 32'h0,   1, 0, 0, 0, 0, 32'h0,   0, 0);

        foreach (tbl[i]) begin
            cycle(tbl[i].iv, instr_of(tbl[i].pc), tbl[i].pc, tbl[i].ordy, tbl[i].br, tbl[i].rd, tbl[i].fl);
            check($sformatf("vec%0d.count", i),      64'(bus.count),      64'(tbl[i].cnt));
            check($sformatf("vec%0d.out_valid", i),  64'(bus.out_valid),  64'(tbl[i].cnt != 0));
            check($sformatf("vec%0d.in_ready", i),   64'(bus.in_ready),   64'(tbl[i].cnt < 4));
            check($sformatf("vec%0d.out_is_ds", i),  64'(bus.out_is_ds),  64'(tbl[i].ds));
            check($sformatf("vec%0d.ds_pending", i), 64'(bus.ds_pending), 64'(tbl[i].dsp));
            if (tbl[i].cnt != 0) begin
                check($sformatf("vec%0d.out_pc", i),    64'(bus.out_pc),        64'(tbl[i].head));
                check($sformatf("vec%0d.out_instr", i), 64'(bus.out_instr),     64'(instr_of(tbl[i].head)));
                check($sformatf("vec%0d.pc_plus_4", i), 64'(bus.out_pc_plus_4), 64'(tbl[i].head + 32'd4));
            end
        end

        // Pointer wrap over three full fill/drain rounds
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 4; k++) begin
                cycle(1'b1, $urandom, 32'h900 + 32'(16 * r + 4 * k), 1'b0, 1'b0, 1'b0, 1'b0);
                check_model($sformatf("wrap%0d.fill%0d", r, k));
            end
            for (int k = 0; k < 4; k++) begin
                cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
                check_model($sformatf("wrap%0d.drain%0d", r, k));
            end
        end

        // Random traffic against the queue model
        for (int n = 0; n < 3000; n++) begin
            logic iv, ordy, br, rd, fl;
            iv   = ($urandom_range(0, 9) < 7);
            ordy = ($urandom_range(0, 9) < 6);
            br   = 1'($urandom_range(0, 1));
            rd   = ordy && br && (mq.size() != 0) && ($urandom_range(0, 2) == 0);
            fl   = ($urandom_range(0, 31) == 0);
            cycle(iv, $urandom, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, ordy, br, rd, fl);
            check_model($sformatf("rand%0d", n));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/id_instr_queue.md
Name: id_instr_queue

Overview:
- Parametrised instruction queue between the IF/ID boundary and the decode stage.
- Replaces the single-register IF/ID hand-off with a DEPTH-entry FIFO of {instr, pc}.
- Generalises the 1-bit delay-slot flag (is_ds) tracking, and keeps the branch delay slot when a taken branch or jump redirects fetch.
- Adds exception flush and a WAIT_DS state for when the delay slot has not yet been fetched.

Parameters:
- DEPTH, 4, number of queue entries (power of two, >=2)
- INSTR_W, 32, instruction word width
- PC_W, 32, program counter width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  IF presents a fetched instruction
- in_ready  out  1  queue can accept; equals (count < DEPTH)
- in_instr  in  INSTR_W  fetched instruction word
- in_pc  in  PC_W  PC of in_instr
- out_valid  out  1  head entry valid; equals (count != 0)
- out_ready  in  1  decode consumes head; driven as !StallD
- out_instr  out  INSTR_W  head instruction
- out_pc  out  PC_W  head PC
- out_pc_plus_4  out  PC_W  out_pc + 4, modulo 2^PC_W
- out_is_ds  out  1  head instruction sits in a branch delay slot
- dec_is_branch  in  1  decoder isBranch for the current head
- redirect  in  1  head branch/jump is taken; valid only with a pop
- flush  in  1  exception or eret; discards everything
- ds_pending  out  1  high in WAIT_DS; IF must fetch one sequential word before redirecting
- count  out  $clog2(DEPTH+1)  occupancy

Behaviour:
- Reset (rst=0, async): count=0, rd/wr pointers=0, state=NORMAL, last_br=0.
  - Resulting outputs: out_valid=0, in_ready=1, out_is_ds=0, ds_pending=0.
  - Entry contents are don't-care.
- Definitions: push = in_valid & in_ready; pop = out_valid & out_ready.
- Latency: a pushed entry becomes visible at the head the cycle after push. There is no bypass.
- Full queue: in_ready=0 even if a pop happens the same cycle.
- Pointers: width log2(DEPTH), natural wrap. Simultaneous push+pop leaves count unchanged.
- Head outputs are combinational from the entry at the read pointer.
- last_br register:
  - On pop: last_br <= dec_is_branch.
  - Without pop: holds (stall-safe).
  - out_is_ds = last_br & out_valid.
- States:
  - NORMAL: default.
  - WAIT_DS: a redirect happened with no delay slot in the queue.
- Redirect in NORMAL (pop & dec_is_branch & redirect):
  - If count >= 2: keep only the entry after the head (the delay slot); count <= 1; discard the rest; ignore any same-cycle push.
  - If count == 1 and push: keep the pushed entry as the delay slot; count <= 1.
  - If count == 1 and no push: count <= 0; go to WAIT_DS.
- WAIT_DS:
  - ds_pending=1.
  - The first push is the delay slot: count <= 1, go to NORMAL.
  - last_br stays 1 until that entry pops.
- redirect without pop, or with dec_is_branch=0: ignored. Assertion error in simulation.
- flush: highest priority over push, pop and redirect.
  - Next cycle: count=0, pointers=0, state=NORMAL, last_br=0.
  - A same-cycle push is dropped.
- A redirect in the delay-slot instruction itself (branch in delay slot) is treated like any other redirect.

Decomposition:
- Shared package id_pkg holds:
  - state enum {NORMAL, WAIT_DS};
  - typedef entry_t {instr, pc};
  - localparam PC_STEP=4.
- Sub-module id_queue_ram: DEPTH x (INSTR_W+PC_W) register array with one write port and a combinational read port.
- Pointer, count, state and delay-slot logic live in id_instr_queue.

Test Plan:
1. Reset mid-operation: fill 3 entries, pull rst low between edges.
   -> Immediately count=0, out_valid=0, in_ready=1, ds_pending=0.
2. Fill/drain:
   - Push pc 0x100..0x10C with out_ready=0 -> count=4, in_ready=0, push of 0x110 refused.
   - Pop all -> PCs appear in order, out_pc_plus_4=0x104 for the first.
   - Pointer wrap checked over 3 full cycles.
3. Delay-slot flag: pop a branch at 0x200 (dec_is_branch=1), hold out_ready=0 for 3 cycles.
   -> out_is_ds=1 for 0x204 throughout the stall; 0 after 0x204 pops.
4. Redirect with queued slot: queue {0x300 br, 0x304, 0x308, 0x30C}, pop with redirect=1.
   -> Next cycle count=1, head 0x304, out_is_ds=1; 0x308 and 0x30C are never presented.
5. Redirect, empty queue: queue {0x400 br}, pop with redirect=1, no push.
   -> state WAIT_DS, ds_pending=1.
   - Push 0x404 -> ds_pending=0, head 0x404 with out_is_ds=1.
6. Flush priority: flush=1 together with push 0x500, pop and redirect.
   -> Next cycle count=0, state NORMAL, out_is_ds=0; 0x500 is absent.
